mdio_read_seq_ctrl: RTL
=======================

Name: mdio_read_seq_ctrl

Overview:
- Autonomous sequencer for the MDIO capture-memory read path.
- On a start pulse it sweeps the lane select and memory address, issuing one read pulse per word and waiting a fixed read latency.
- Each returned 9-bit word is captured and presented on a valid/ready output toward the packet/register interface.
- Replaces software-driven single reads; drives the read-enable, select and address inputs of the MDIO read-logic block.

Parameters:
- ADDR_W, 15, memory address width.
- SEL_W, 7, lane-select width (96 lanes max).
- DATA_W, 9, read word width.
- READ_LAT, 3, cycles from rd_pulse high to rd_data valid at this block's input (legal 1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- abort  in  1  level/pulse; terminates the sweep.
- path96_en  in  1  1: last select 95; 0: last select 47. Sampled at start.
- cfg_addr_first  in  ADDR_W  first address per select. Sampled at start.
- cfg_addr_last  in  ADDR_W  last address per select. Sampled at start.
- rd_data  in  DATA_W  returned word from the read path.
- mdio_read_en  out  1  high while busy.
- rd_pulse  out  1  one-cycle read strobe.
- rd_sel  out  SEL_W  current lane select.
- rd_addr  out  ADDR_W  current memory address.
- out_valid  out  1  output word valid.
- out_data  out  DATA_W  captured word.
- out_ready  in  1  consumer accepts the word.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse at sweep completion (not on abort).

Behaviour:
- Reset value of every output is 0.
- Reset is asynchronous and active-high. Asserting reset mid-sweep returns the FSM to IDLE immediately and discards the held word.
- Scan order: select is the outer loop (0..sel_last); address is the inner loop (addr_first..addr_last).
- If cfg_addr_first > cfg_addr_last at start, the start is ignored; the FSM stays in IDLE and done is not pulsed.
- FSM states: IDLE, ISSUE, WAIT, HOLD, FIN.
  - IDLE: on start, latch cfg and path96_en, set sel=0 and addr=addr_first, go to ISSUE. A start pulse in any other state is ignored.
  - ISSUE: rd_pulse=1 for exactly one cycle with rd_sel/rd_addr stable; load the latency counter with READ_LAT-1; go to WAIT.
  - WAIT: decrement the counter. At 0, register rd_data into out_data, set out_valid, go to HOLD.
  - HOLD: out_valid held and out_data stable until out_ready. The handshake completes when out_valid && out_ready.
    - On completion with addr==addr_last and sel==sel_last: clear out_valid, go to FIN.
    - On completion with addr==addr_last only: addr=addr_first, sel+1, go to ISSUE.
    - Otherwise: addr+1, go to ISSUE.
  - FIN: done=1 for one cycle, go to IDLE.
- rd_sel and rd_addr hold their values outside ISSUE and are cleared to 0 in IDLE.
- mdio_read_en equals busy.
- abort: in any non-IDLE state, the next state is IDLE, out_valid is cleared the following cycle, and done is not pulsed.
- abort and handshake in the same cycle: the word counts as consumed; abort still wins.
- Throughput: one word per READ_LAT+2 cycles with out_ready tied high.
- Address increment never wraps, because the last-address compare precedes the increment.

Optional Feature:
- Macro: MDIO_SEQ_WORD_CNT_EN.
- Defined: adds output word_cnt [23:0].
  - Cleared on start.
  - Increments on each out handshake.
  - Saturates at 24'hFFFFFF.
  - Holds its value after done or abort until the next start.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mdio_seq_pkg:
  - FSM state encoding.
  - SEL_LAST_48=7'd47, SEL_LAST_96=7'd95.
  - Default ADDR_W/SEL_W/DATA_W constants.
- Sub-module mdio_seq_idx_gen:
  - Holds the sel/addr registers, load, and advance.
  - Outputs is_last_addr and is_last_word.
  - Instantiated once.

Test Plan:
- Reset then idle: all outputs 0. Start with path96_en=0, addr 0..1, out_ready=1 -> 96 words (sel 0..47 × 2 addresses) in order; rd_pulse spacing 5 cycles (READ_LAT=3); single done pulse; busy falls the cycle after done.
- rd_data model returns {sel[3:0],addr[4:0]}, path96_en=1, addr 5..5 -> out_data sequence matches for sel 0..95; last word sel=95; done asserted.
- out_ready held low 10 cycles in HOLD -> out_valid/out_data stable; no rd_pulse issued; sweep resumes one cycle after ready.
- abort asserted during WAIT of word 3 -> IDLE next cycle, out_valid 0, no done; a following start restarts at sel 0, addr_first.
- cfg_addr_first=10, cfg_addr_last=4 -> start ignored, busy stays 0; start pulsed while busy -> ignored, sequence unchanged.
- Reset asserted in HOLD -> all outputs 0 asynchronously. With MDIO_SEQ_WORD_CNT_EN, word_cnt equals 96 after a full 48-path 2-address sweep.

Source files
------------

// File: rtl/mdio_seq_pkg.sv
// Shared definitions for the MDIO capture-memory read sequencer.
//   - default widths and read latency
//   - last lane select for the 48-lane and 96-lane paths
//   - FSM state encoding
package mdio_seq_pkg;

  localparam int ADDR_W_DEF   = 15;
  localparam int SEL_W_DEF    = 7;
  localparam int DATA_W_DEF   = 9;
  localparam int READ_LAT_DEF = 3;
  localparam int LAT_CNT_W    = 3;   // holds READ_LAT-1 for READ_LAT up to 7
  localparam int WORD_CNT_W   = 24;

  localparam logic [6:0] SEL_LAST_48 = 7'd47;
  localparam logic [6:0] SEL_LAST_96 = 7'd95;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FIN   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/mdio_seq_idx_gen.sv
// Lane-select / address index generator for the read sequencer.
// Latches the sweep configuration on load, then steps the address
// (inner loop) and lane select (outer loop) on each advance.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load_i              latch cfg, sel=0, addr=addr_first
//   clear_i             return sel/addr to 0 (sequencer going idle)
//   advance_i           step to the next word
//   path96_en_i         selects last lane 95 (1) or 47 (0)
//   addr_first_i/last_i address range per lane
//   sel_o, addr_o       current lane select and address
//   is_last_addr_o      addr == latched addr_last
//   is_last_word_o      last address of the last lane
module mdio_seq_idx_gen
  import mdio_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic              path96_en_i,
  input  logic [ADDR_W-1:0] addr_first_i,
  input  logic [ADDR_W-1:0] addr_last_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              is_last_addr_o,
  output logic              is_last_word_o
);

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  sel_last_q, sel_last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;

  assign is_last_addr_o = (addr_q == last_q);
  assign is_last_word_o = is_last_addr_o && (sel_q == sel_last_q);

  always_comb begin
    // NOTE: every next-state variable takes its held value first so no path leaves it unassigned (no latch).
    sel_d      = sel_q;
    sel_last_d = sel_last_q;
    addr_d     = addr_q;
    first_d    = first_q;
    last_d     = last_q;
    if (clear_i) begin
      sel_d  = '0;
      addr_d = '0;
    end else if (load_i) begin
      sel_d      = '0;
      addr_d     = addr_first_i;
      first_d    = addr_first_i;
      last_d     = addr_last_i;
      sel_last_d = path96_en_i ? SEL_W'(SEL_LAST_96) : SEL_W'(SEL_LAST_48);
    end else if (advance_i) begin
      // The last-address compare comes first, so the address never wraps.
      if (is_last_addr_o) begin
        addr_d = first_q;
        sel_d  = sel_q + 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= '0;
      sel_last_q <= '0;
      addr_q     <= '0;
      first_q    <= '0;
      last_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sel_q      <= sel_d;
      sel_last_q <= sel_last_d;
      addr_q     <= addr_d;
      first_q    <= first_d;
      last_q     <= last_d;
    end
  end

  assign sel_o  = sel_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/mdio_read_seq_ctrl.sv
// Autonomous MDIO capture-memory read sequencer.
// On start it sweeps lane select (outer) and address (inner), issues one
// rd_pulse per word, waits READ_LAT cycles, captures rd_data and offers it
// on a valid/ready output. Optional build macro MDIO_SEQ_WORD_CNT_EN adds
// a saturating 24-bit accepted-word counter on port word_cnt.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   start, abort                 begin sweep (idle only) / terminate sweep
//   path96_en                    last lane 95 (1) or 47 (0), sampled at start
//   cfg_addr_first/last          address range per lane, sampled at start
//   rd_data                      word returned by the read path
//   mdio_read_en, rd_pulse       read-path enable and one-cycle strobe
//   rd_sel, rd_addr              current lane select and address
//   out_valid, out_data, out_ready  output handshake
//   busy, done                   not idle / one-cycle completion pulse
//   word_cnt (optional)          accepted words since last start
module mdio_read_seq_ctrl
  import mdio_seq_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              path96_en,
  input  logic [ADDR_W-1:0] cfg_addr_first,
  input  logic [ADDR_W-1:0] cfg_addr_last,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              out_ready,
  output logic              mdio_read_en,
  output logic              rd_pulse,
  output logic [SEL_W-1:0]  rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
`ifdef MDIO_SEQ_WORD_CNT_EN
  ,
  output logic [WORD_CNT_W-1:0] word_cnt
`endif
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LAT - 1);

  seq_state_e            state_q, state_d;
  logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;

  logic accept_start, handshake, capture, is_last_addr, is_last_word;
  logic idx_load, idx_clear, idx_advance;

  assign accept_start = (state_q == ST_IDLE) && start && (cfg_addr_first <= cfg_addr_last);
  assign handshake    = out_valid_q && out_ready;
  assign capture      = (state_q == ST_WAIT) && (lat_cnt_q == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept_start) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (capture) state_d = ST_HOLD;
      ST_HOLD:  if (handshake) state_d = (is_last_addr && is_last_word) ? ST_FIN : ST_ISSUE;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Output logic.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    mdio_read_en = busy;
    rd_pulse     = (state_q == ST_ISSUE);
    done         = (state_q == ST_FIN) && !abort;
    out_valid    = out_valid_q;
    out_data     = out_data_q;
  end

  // Latency counter and captured word.
  always_comb begin
    lat_cnt_d   = lat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (state_q == ST_ISSUE)                      lat_cnt_d = LAT_LOAD;
    else if (state_q == ST_WAIT && !capture)      lat_cnt_d = lat_cnt_q - 1'b1;
    if (handshake) out_valid_d = 1'b0;
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_data;
    end
    if (abort && (state_q != ST_IDLE)) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      lat_cnt_q   <= lat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign idx_load    = accept_start;
  assign idx_clear   = (state_q != ST_IDLE) && (state_d == ST_IDLE);
  assign idx_advance = (state_q == ST_HOLD) && handshake && !is_last_word;

  mdio_seq_idx_gen #(
    .ADDR_W(ADDR_W),
    .SEL_W (SEL_W)
  ) u_idx_gen (
    .clk           (clk),
    .rst           (rst),
    .load_i        (idx_load),
    .clear_i       (idx_clear),
    .advance_i     (idx_advance),
    .path96_en_i   (path96_en),
    .addr_first_i  (cfg_addr_first),
    .addr_last_i   (cfg_addr_last),
    .sel_o         (rd_sel),
    .addr_o        (rd_addr),
    .is_last_addr_o(is_last_addr),
    .is_last_word_o(is_last_word)
  );

`ifdef MDIO_SEQ_WORD_CNT_EN
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (accept_start)                        word_cnt_d = '0;
    else if (handshake && word_cnt_q != '1)  word_cnt_d = word_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_cnt_q <= '0;
    else     word_cnt_q <= word_cnt_d;
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule
